imem_load_arb: RTL

IMEM_LOAD_ARB -- requirements
Module: imem_load_arb

---
 rtl/imem_load_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/imem_load_arb.sv
// imem_load_arb: arbitrates one instruction-memory port between CPU fetch
// and a byte-wide program loader. A load session holds the CPU stalled and
// is followed by a one-cycle flush pulse so the CPU restarts cleanly.
module imem_load_arb #(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int ADDRESS_REAL_WIDTH = 12,
  parameter int DATA_WIDTH         = 8,
  parameter int DATA_OUT_WIDTH     = 32,
  parameter int IDLE_TIMEOUT       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          fetch_req,
  input  logic [ADDRESS_WIDTH-1:0]      fetch_addr,
  output logic                          fetch_gnt,
  output logic                          fetch_valid,
  output logic [DATA_OUT_WIDTH-1:0]     fetch_rdata,
  output logic                          fetch_err,
  input  logic                          ld_valid,
  input  logic [ADDRESS_WIDTH-1:0]      ld_addr,
  input  logic [DATA_WIDTH-1:0]         ld_data,
  input  logic                          ld_done,
  output logic                          ld_ready,
  output logic [ADDRESS_WIDTH-1:0]      mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_OUT_WIDTH-1:0]     mem_rdata,
  output logic                          cpu_stall,
  output logic                          cpu_flush,
  output logic [ADDRESS_REAL_WIDTH:0]   ld_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADING = 2'd1,
    FLUSH   = 2'd2
  } state_e;

  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int CNT_W  = ADDRESS_REAL_WIDTH + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic                      lastGrant_q, lastGrant_d;
  logic [IDLE_W-1:0]         idleCnt_q, idleCnt_d;
  logic [CNT_W-1:0]          ldCount_q, ldCount_d;
  logic                      fetchValid_q;
  logic [DATA_OUT_WIDTH-1:0] fetchRdata_q;
  logic                      fetchErr_q;

  logic fetchGnt;
  logic ldGnt;
  logic inRange;

  // lastGrant_q = 1 means the loader was granted last, so fetch is favoured.
  assign inRange = ((ld_addr >> ADDRESS_REAL_WIDTH) == '0);

  // Grant decision: round-robin in IDLE, loader only in LOADING, none in FLUSH.
  always_comb begin
    fetchGnt = 1'b0;
    ldGnt    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          ldGnt    = ld_valid & (~fetch_req | ~lastGrant_q);
          fetchGnt = fetch_req & ~ldGnt;
        end
        LOADING: ldGnt = ld_valid;
        default: ;
      endcase
    end
  end

  // Next-state, idle timer, session byte counter and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    lastGrant_d = lastGrant_q;
    idleCnt_d   = idleCnt_q;
    ldCount_d   = ldCount_q;
    if (ldGnt) begin
      lastGrant_d = 1'b1;
    end else if (fetchGnt) begin
      lastGrant_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (ldGnt) begin
          state_d   = LOADING;
          idleCnt_d = '0;
          ldCount_d = inRange ? CNT_W'(1) : '0;
        end
      end
      LOADING: begin
        if (ldGnt) begin
          idleCnt_d = '0;
          if (inRange && (ldCount_q != '1)) begin
            ldCount_d = ldCount_q + CNT_W'(1);
          end
        end else if (idleCnt_q != IDLE_LAST) begin
          idleCnt_d = idleCnt_q + IDLE_W'(1);
        end
        if (ld_done || (!ldGnt && (idleCnt_q == IDLE_LAST))) begin
          state_d = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset aborts any session without a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lastGrant_q  <= 1'b1;
      idleCnt_q    <= '0;
      ldCount_q    <= '0;
      fetchValid_q <= 1'b0;
      fetchRdata_q <= '0;
      fetchErr_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lastGrant_q  <= lastGrant_d;
      idleCnt_q    <= idleCnt_d;
      ldCount_q    <= ldCount_d;
      fetchValid_q <= fetchGnt;
      if (fetchGnt) begin
        fetchRdata_q <= mem_rdata;
        if (fetch_addr[1:0] != 2'b00) begin
          fetchErr_q <= 1'b1;
        end
      end
    end
  end

  assign fetch_gnt   = fetchGnt;
  assign ld_ready    = ldGnt;
  assign mem_we      = ldGnt & inRange;
  assign mem_addr    = ldGnt ? ld_addr : (fetchGnt ? fetch_addr : '0);
  assign mem_wdata   = ldGnt ? ld_data : '0;
  assign fetch_valid = fetchValid_q;
  assign fetch_rdata = fetchRdata_q;
  assign fetch_err   = fetchErr_q;
  assign ld_count    = ldCount_q;
  assign cpu_flush   = ~rst & (state_q == FLUSH);
  assign cpu_stall   = ~rst & ((state_q != IDLE) | (fetch_req & ~fetchGnt));

endmodule
